// File: rtl/syrup_channel_buffer_pkg.sv
// Shared defaults for the Syrup channel buffer and its storage.
package syrup_channel_buffer_pkg;

  localparam int SYRUP_DATA_WIDTH_DEF = 32;
  localparam int SYRUP_ADDR_LEN_DEF   = 4;
  localparam int SYRUP_CNT_WIDTH_DEF  = 32;

endpackage

// File: rtl/syrup_channel_ram.sv
// Simple dual-port RAM: synchronous write, registered read that holds its value
// between reads and clears on reset.
module syrup_channel_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LEN   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_LEN-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_LEN-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_LEN;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/syrup_channel_buffer.sv
// Fabric-side end of a Syrup channel: circular FIFO between the out-channel write
// stream and the in-channel read stream, with STALL to freeze the user clock.
module syrup_channel_buffer
  import syrup_channel_buffer_pkg::*;
#(
  parameter string DOMAIN     = "domain",
  parameter int    ID         = 0,
  parameter int    DATA_WIDTH = SYRUP_DATA_WIDTH_DEF,
  parameter int    ADDR_LEN   = SYRUP_ADDR_LEN_DEF,
  parameter int    CNT_WIDTH  = SYRUP_CNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  WE,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  RE,
  output logic                  STALL,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_LEN:0]     COUNT,
  output logic [CNT_WIDTH-1:0]  STALL_CYCLES
);

  // DOMAIN/ID only identify the channel; reject meaningless values at elaboration.
  if (DOMAIN == "") begin : g_bad_domain
    $error("syrup_channel_buffer: DOMAIN must be non-empty");
  end
  if (ID < 0) begin : g_bad_id
    $error("syrup_channel_buffer: ID must be non-negative");
  end

  localparam logic [ADDR_LEN:0] DEPTH = (ADDR_LEN+1)'(1) << ADDR_LEN;

  logic [ADDR_LEN-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0]    count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 rd_ok, wr_ok, stall;

  // No bypass: a read against an empty FIFO waits even if a write lands this cycle.
  always_comb begin
    rd_ok = RE & ~empty_q & ~RST;
    wr_ok = WE & (~full_q | rd_ok) & ~RST;
    stall = ~RST & ((WE & ~wr_ok) | (RE & ~rd_ok));
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_LEN'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_LEN'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_LEN+1)'(1);
      2'b01:   count_d = count_q - (ADDR_LEN+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  syrup_channel_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_LEN  (ADDR_LEN)
  ) u_ram (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(D),
    .re_i   (rd_ok),
    .raddr_i(rd_ptr_q),
    .rdata_o(Q)
  );

  assign STALL        = stall;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign COUNT        = count_q;
  assign STALL_CYCLES = stall_cnt_q;

endmodule

// File: tb/tb_syrup_channel_buffer.sv
// Bench for syrup_channel_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_syrup_channel_buffer;

  localparam int DW    = 8;
  localparam int AL    = 2;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AL;

  // clock / reset
  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] D   = '0;
  logic          WE  = 1'b0;
  logic          RE  = 1'b0;
  logic [DW-1:0] Q;
  logic          STALL, FULL, EMPTY;
  logic [AL:0]   COUNT;
  logic [CW-1:0] STALL_CYCLES;

  always #5 clk = ~clk;

  syrup_channel_buffer #(
    .DOMAIN("tb"), .ID(3), .DATA_WIDTH(DW), .ADDR_LEN(AL), .CNT_WIDTH(CW)
  ) dut (
    .CLK(clk), .RST(RST), .D(D), .WE(WE), .Q(Q), .RE(RE), .STALL(STALL),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .STALL_CYCLES(STALL_CYCLES)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, last read value, stall tally
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_qout  = '0;
  int            mdl_stalls = 0;
  bit            armed = 1'b0;

  function automatic bit mdl_rd(input logic re);
    return re && exp_q.size() > 0;
  endfunction

  function automatic bit mdl_wr(input logic we, input logic re);
    return we && (exp_q.size() < DEPTH || mdl_rd(re));
  endfunction

  function automatic bit mdl_stall(input logic rst, input logic we, input logic re);
    if (rst) return 1'b0;
    return (we && !mdl_wr(we, re)) || (re && !mdl_rd(re));
  endfunction

  always @(posedge clk) begin
    if (RST) begin
      exp_q.delete();
      mdl_qout   = '0;
      mdl_stalls = 0;
      armed      = 1'b1;
    end else if (armed) begin
      bit rd, wr, st;
      rd = mdl_rd(RE);
      wr = mdl_wr(WE, RE);
      st = mdl_stall(1'b0, WE, RE);
      if (rd) mdl_qout = exp_q.pop_front();
      if (wr) exp_q.push_back(D);
      if (st && mdl_stalls < (1 << CW) - 1) mdl_stalls++;
    end
  end

  // compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (armed) begin
      check("count", 32'(COUNT), 32'(exp_q.size()));
      check("empty", 32'(EMPTY), 32'(exp_q.size() == 0));
      check("full",  32'(FULL),  32'(exp_q.size() == DEPTH));
      check("q",     32'(Q),     32'(mdl_qout));
      check("stall", 32'(STALL), 32'(mdl_stall(RST, WE, RE)));
      check("stall_cycles", 32'(STALL_CYCLES), 32'(mdl_stalls));
    end
  end

  // driver tasks
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    RST = r; WE = w; RE = rd; D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // 1. reset
    do_reset(2);
    step(1'b0, 1'b0, 1'b0, '0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full",  32'(FULL),  32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_q",     32'(Q),     32'd0);
    check("rst_stall", 32'(STALL), 32'd0);

    // 2. streaming: writes lead reads by three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    for (int i = 3; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, DW'(i));
      check("stream_q", 32'(Q), 32'(i - 3));
      check("stream_count", 32'(COUNT), 32'd3);
    end

    // 3. fill then blocked write; stall counter saturates at 15
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(8'h10 + i));
    check("fill_full",  32'(FULL),  32'd1);
    check("fill_count", 32'(COUNT), 32'd4);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 8'h55);
    check("blocked_count", 32'(COUNT), 32'd4);
    check("stall_sat", 32'(STALL_CYCLES), 32'd15);

    // 4. full with simultaneous write and read
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("full_rw_q", 32'(Q), 32'h10);
    check("full_rw_count", 32'(COUNT), 32'd4);
    check("full_rw_full", 32'(FULL), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0);
    check("drain_last", 32'(Q), 32'h55);

    // 5. read from empty waits; pending read completes after a write
    do_reset(1);
    step(1'b0, 1'b1, 1'b0, 8'h11);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("empty_hold_q", 32'(Q), 32'h11);
    check("empty_stall", 32'(STALL), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    check("nobypass_q", 32'(Q), 32'h11);
    step(1'b0, 1'b0, 1'b1, '0);
    check("pending_q", 32'(Q), 32'hA5);

    // 6. pointer wrap
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(i));
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      check("wrap_q", 32'(Q), 32'(i));
    end

    // 7. reset with data inside
    do_reset(1);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    step(1'b0, 1'b0, 1'b1, '0);
    check("mid_count", 32'(COUNT), 32'd3);
    check("mid_q", 32'(Q), 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    check("mid_rst_empty", 32'(EMPTY), 32'd1);
    check("mid_rst_count", 32'(COUNT), 32'd0);
    check("mid_rst_q", 32'(Q), 32'd0);

    // random traffic: requests held while the model says they stall
    step(1'b0, 1'b0, 1'b0, '0);
    begin
      int wp, rp;
      wp = 50; rp = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 150 == 0) begin
          wp = $urandom_range(10, 90);
          rp = $urandom_range(10, 90);
        end
        if (!RST && mdl_stall(1'b0, WE, RE)) begin
          step(1'b0, WE, RE, D);
        end else begin
          step($urandom_range(0, 199) == 0,
               $urandom_range(0, 99) < wp,
               $urandom_range(0, 99) < rp,
               DW'($urandom));
        end
      end
    end

    step(1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
